// File: rtl/int_wb_bridge.sv
// rtl/int_wb_bridge.sv - 16-bit requester to 32-bit Wishbone B3 bridge (optional error path: INT_WB_BRIDGE_ERR_EN)
module int_wb_bridge #(
  parameter int ADR_WIDTH = 32
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_rst_n,
  input  logic                 acc_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [15:0]          dat_i,
  input  logic [1:0]           sel_i,
  output logic                 ack_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [15:0]          dat_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i
`ifdef INT_WB_BRIDGE_ERR_EN
  ,
  input  logic                 wb_err_i,
  output logic                 err_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_BUS,
    S_RD_BUS,
    S_STREAM
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_dat_hi;
  logic [1:0]             r_sel_hi;
  logic [ADR_WIDTH-1:0]   r_wadr;
  logic [1:0]             r_k;
  logic [2:0]             r_b;
  logic [31:0]            r_buf [4];

  logic                   w_err;
  logic                   w_term;
  logic [31:0]            w_rd_word;
  logic [2:0]             w_nb;
  logic [31:0]            w_word;
  logic [1:0]             w_widx;
  logic                   w_unused;

`ifdef INT_WB_BRIDGE_ERR_EN
  assign w_err = wb_err_i;
`else
  assign w_err = 1'b0;
`endif

  // A bus beat ends on ack or error; errored read words are replaced by zero.
  assign w_term    = wb_ack_i | w_err;
  assign w_rd_word = w_err ? 32'h0 : wb_dat_i;

  // Next stream beat: word index inside the line wraps from the start word.
  assign w_nb     = r_b + 3'd1;
  assign w_word   = r_buf[w_nb[2:1]];
  assign w_widx   = r_wadr[3:2] + w_nb[2:1];
  assign w_unused = ^adr_i[1:0];

  // State register.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // Next-state logic; new requests are only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (acc_i) w_next = we_i ? S_WR_LO : S_RD_BUS;
      S_WR_LO:  w_next = S_WR_BUS;
      S_WR_BUS: if (w_term) w_next = S_IDLE;
      S_RD_BUS: if (w_term && (r_k == 2'd3)) w_next = S_STREAM;
      S_STREAM: if (r_b == 3'd7) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; reset aborts any bus cycle at once.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      ack_o    <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cti_o <= 3'b000;
      wb_bte_o <= 2'b00;
      r_dat_hi <= '0;
      r_sel_hi <= '0;
      r_wadr   <= '0;
      r_k      <= '0;
      r_b      <= '0;
`ifdef INT_WB_BRIDGE_ERR_EN
      err_o    <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (acc_i) begin
            r_wadr <= {adr_i[ADR_WIDTH-1:2], 2'b00};
            if (we_i) begin
              r_dat_hi <= dat_i;
              r_sel_hi <= sel_i;
              ack_o    <= 1'b1;
            end else begin
              wb_adr_o <= {adr_i[ADR_WIDTH-1:2], 2'b00};
              wb_we_o  <= 1'b0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_cti_o <= 3'b010;
              wb_bte_o <= 2'b01;
              r_k      <= 2'd0;
            end
          end
        end
        S_WR_LO: begin
          wb_adr_o <= r_wadr;
          wb_dat_o <= {r_dat_hi, dat_i};
          wb_sel_o <= {r_sel_hi, sel_i};
          wb_we_o  <= 1'b1;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_cti_o <= 3'b000;
          wb_bte_o <= 2'b00;
        end
        S_WR_BUS: begin
          if (w_term) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
          end
        end
        S_RD_BUS: begin
          if (w_term) begin
            r_k           <= r_k + 2'd1;
            wb_adr_o[3:2] <= wb_adr_o[3:2] + 2'd1;
            if (r_k == 2'd2) wb_cti_o <= 3'b111;
            if (r_k == 2'd3) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_cti_o <= 3'b000;
              wb_bte_o <= 2'b00;
              ack_o    <= 1'b1;
              adr_o    <= r_wadr;
              dat_o    <= r_buf[0][31:16];
              r_b      <= 3'd0;
            end
          end
        end
        S_STREAM: begin
          if (r_b != 3'd7) begin
            r_b   <= w_nb;
            adr_o <= {r_wadr[ADR_WIDTH-1:4], w_widx, w_nb[0], 1'b0};
            dat_o <= w_nb[0] ? w_word[15:0] : w_word[31:16];
          end
        end
        default: ;
      endcase
`ifdef INT_WB_BRIDGE_ERR_EN
      if (w_err && ((r_state == S_WR_BUS) || (r_state == S_RD_BUS))) err_o <= 1'b1;
`endif
    end
  end

  // Line buffer filled in burst order, slot k holds the k-th word returned.
  always_ff @(posedge sdram_clk) begin
    if ((r_state == S_RD_BUS) && w_term) r_buf[r_k] <= w_rd_word;
  end

endmodule

// File: doc/int_wb_bridge.md
INT_WB_BRIDGE -- requirements
Module: int_wb_bridge

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32, width of adr_i, adr_o and wb_adr_o.
REQ-002 SHALL have one clock and asynchronous active-low reset: sdram_clk  in  1  sole clock, all logic on rising edge.
REQ-003 sdram_rst_n  in  1  asynchronous active-low reset.
REQ-004 acc_i  in  1  access request, level, held by requester until ack_o.
REQ-005 we_i  in  1  1=write, 0=read; valid with acc_i.
REQ-006 adr_i  in  ADR_WIDTH  byte address; bit1=0 selects upper half-word.
REQ-007 dat_i  in  16  write half-word.
REQ-008 sel_i  in  2  write byte enables for dat_i.
REQ-009 ack_o  out  1  one-cycle acknowledge.
REQ-010 adr_o  out  ADR_WIDTH  address of current read beat.
REQ-011 dat_o  out  16  read half-word.
REQ-012 wb_adr_o, wb_dat_o[31:0], wb_sel_o[3:0], wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0]  out  Wishbone B3 master outputs.
REQ-013 wb_dat_i[31:0], wb_ack_i  in  Wishbone master inputs.

Function
REQ-014 States IDLE, WR_LO, WR_BUS, RD_BUS, STREAM; requests sampled only in IDLE.
REQ-015 IDLE, acc_i&we_i at edge T: capture dat_i/sel_i as upper half, {adr_i[ADR_WIDTH-1:2],2'b00} as word address, go WR_LO; ack_o=1 during cycle T+1.
REQ-016 WR_LO: at end of T+1 capture dat_i/sel_i as lower half (requester presents adr+2 data while ack_o high), go WR_BUS.
REQ-017 WR_BUS: cyc=stb=we=1, cti=000, bte=00, dat={hi,lo}, sel={sel_hi,sel_lo} (issued even if sel=0) held until wb_ack_i, then cyc/stb low, IDLE.
REQ-018 IDLE, acc_i&!we_i: go RD_BUS, cyc=stb=1, we=0, cti=010, bte=01 (wrap-4), wb_adr_o=requested word address.
REQ-019 RD_BUS: each wb_ack_i stores wb_dat_i into 4x32 buffer slot k and advances wb_adr_o[3:2] by 1 modulo 4; cti=111 while 4th word pending; after 4th ack cyc/stb low, go STREAM.
REQ-020 STREAM: 8 consecutive cycles, beat b=0..7: word (start+b/2) mod 4 of same 16-byte line, upper half then lower half; adr_o bit1=b[0]; ack_o=1 only on beat 0; return IDLE after beat 7.
REQ-021 Read latency: beat 0 appears cycle after the 4th wb_ack_i; no gaps inside stream.
REQ-022 acc_i high during STREAM or bus states (requester re-arming second burst) SHALL be ignored and serviced from IDLE afterwards; no request lost.
REQ-023 wb_stb_o SHALL never be high without wb_cyc_o; outputs registered.
REQ-024 adr_o/dat_o SHALL hold last values outside STREAM.

Reset
REQ-025 Assertion of sdram_rst_n=0 SHALL immediately force IDLE, all outputs 0 (ack_o, adr_o, dat_o, wb_* incl. cti=000, bte=00), aborting any bus cycle or stream; buffer content undefined.
REQ-026 First request after deassertion SHALL be accepted at the first edge with reset released.

Configuration
REQ-027 Macro INT_WB_BRIDGE_ERR_EN defined: input wb_err_i and sticky output err_o exist; wb_err_i terminates the beat like wb_ack_i, read word stored as 0, err_o set until reset.
REQ-028 Macro undefined: no wb_err_i/err_o ports; beats terminate on wb_ack_i only.

Verification
REQ-029 Write adr=0x100, hi=0xAABB sel=11, lo=0xCCDD sel=01 -> ack_o T+1; one WB write adr=0x100 dat=0xAABBCCDD sel=4'b1101 cti=000.
REQ-030 Read adr=0x208, memory 0x200..0x20C = W0..W3, zero-wait slave -> WB adr 0x208,0x20C,0x200,0x204 cti 010,010,010,111; stream W2hi,W2lo,W3hi,W3lo,W0hi,W0lo,W1hi,W1lo, ack_o on first only.
REQ-031 Read with slave inserting 3 wait states per beat -> stream still 8 gapless cycles, same data order.
REQ-032 acc_i reasserted (read) during STREAM cycle 3 -> second read starts after beat 7, correct data.
REQ-033 sdram_rst_n low mid-RD_BUS -> wb_cyc_o/wb_stb_o 0 same cycle; next read completes normally.
REQ-034 With INT_WB_BRIDGE_ERR_EN, wb_err_i on 2nd read beat -> that word streams 0x0000/0x0000, err_o=1 and stays 1.
